// File: rtl/yuv_matrix_seq_pkg.sv
// Shared constants, default BT.601 coefficient set and FSM encoding for the
// time-multiplexed RGB-to-YUV matrix engine.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

package yuv_matrix_seq_pkg;

  localparam int COEF_W    = 9;
  localparam int FRAC_BITS = 8;
  localparam int ROUND     = 128;
  localparam int NUM_COEF  = 9;
  localparam int COEF_VEC_W = NUM_COEF * COEF_W;

  // Field k = row*3+col, field 0 in the LSBs (Y r, Y g, Y b, U r, ... V b).
  localparam logic [COEF_VEC_W-1:0] COEF_DEFAULT = {
    9'd494, 9'd418, 9'd112,   // V: 112, -94, -18
    9'd112, 9'd438, 9'd474,   // U: -38, -74, 112
    9'd25,  9'd129, 9'd66     // Y:  66, 129,  25
  };

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROW_Y = 2'd1,
    ST_ROW_U = 2'd2,
    ST_ROW_V = 2'd3
  } state_t;

endpackage

// File: rtl/yuv_dot3.sv
// Combinational 3-tap dot product (unsigned pixel x signed Q1.8 coef) with
// round-to-nearest, >>8 and selectable unsigned/signed clamp to PIXEL_WIDTH.
module yuv_dot3
  import yuv_matrix_seq_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic [PIXEL_WIDTH-1:0] a0,
  input  logic [PIXEL_WIDTH-1:0] a1,
  input  logic [PIXEL_WIDTH-1:0] a2,
  input  logic [COEF_W-1:0]      c0,
  input  logic [COEF_W-1:0]      c1,
  input  logic [COEF_W-1:0]      c2,
  input  logic                   clamp_signed,
  output logic [PIXEL_WIDTH-1:0] res
);

  localparam int AW = PIXEL_WIDTH + 11;
  localparam int SW = AW - FRAC_BITS;
  localparam logic signed [AW-1:0] RND = AW'(ROUND);

  logic signed [AW-1:0] ax0, ax1, ax2, cx0, cx1, cx2;
  logic signed [AW-1:0] acc;
  logic signed [SW-1:0] sh;
  logic                 unused_frac;

  assign ax0 = {{(AW-PIXEL_WIDTH){1'b0}}, a0};
  assign ax1 = {{(AW-PIXEL_WIDTH){1'b0}}, a1};
  assign ax2 = {{(AW-PIXEL_WIDTH){1'b0}}, a2};
  assign cx0 = {{(AW-COEF_W){c0[COEF_W-1]}}, c0};
  assign cx1 = {{(AW-COEF_W){c1[COEF_W-1]}}, c1};
  assign cx2 = {{(AW-COEF_W){c2[COEF_W-1]}}, c2};

  assign acc = ax0 * cx0 + ax1 * cx1 + ax2 * cx2 + RND;
  // Slicing off the fraction is the arithmetic shift right by FRAC_BITS.
  assign sh          = acc[AW-1:FRAC_BITS];
  assign unused_frac = ^acc[FRAC_BITS-1:0];

  always_comb begin
    res = sh[PIXEL_WIDTH-1:0];
    if (clamp_signed) begin
      if (sh[SW-1:PIXEL_WIDTH-1] != {(SW-PIXEL_WIDTH+1){sh[SW-1]}})
        res = sh[SW-1] ? {1'b1, {(PIXEL_WIDTH-1){1'b0}}}
                       : {1'b0, {(PIXEL_WIDTH-1){1'b1}}};
    end else begin
      if (sh[SW-1])
        res = '0;
      else if (|sh[SW-2:PIXEL_WIDTH])
        res = '1;
    end
  end

endmodule

// File: rtl/yuv_matrix_seq.sv
// RGB-to-YUV matrix engine: one shared dot-product unit computes Y, U, V on
// successive cycles; coefficient updates are staged and committed only when idle.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module yuv_matrix_seq
  import yuv_matrix_seq_pkg::*;
#(
  parameter int PIXEL_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    resetb,
  input  logic                    enable,
  input  logic                    coef_load,
  input  logic [80:0]             coef,
  output logic                    coef_pend,
  input  logic                    dvi,
  output logic                    rdy,
  input  logic [`DTYPE_WIDTH-1:0] dtypei,
  input  logic [PIXEL_WIDTH-1:0]  r,
  input  logic [PIXEL_WIDTH-1:0]  g,
  input  logic [PIXEL_WIDTH-1:0]  b,
  input  logic [15:0]             meta_datai,
  output logic                    dvo,
  output logic [`DTYPE_WIDTH-1:0] dtypeo,
  output logic [PIXEL_WIDTH-1:0]  y,
  output logic [PIXEL_WIDTH-1:0]  u,
  output logic [PIXEL_WIDTH-1:0]  v,
  output logic [15:0]             meta_datao
);

  state_t state, state_nxt;
  logic   accept;

  logic [COEF_VEC_W-1:0]   coef_act, coef_stg;
  logic [3*COEF_W-1:0]     c_row;
  logic                    clamp_signed;
  logic [PIXEL_WIDTH-1:0]  r_h, g_h, b_h, y_r, u_r, dot_res, row_res;
  logic                    en_h;
  logic [`DTYPE_WIDTH-1:0] dtype_h;
  logic [15:0]             meta_h;

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) state <= ST_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    rdy       = ((state == ST_IDLE) || (state == ST_ROW_V)) && !coef_pend;
    accept    = dvi && rdy;
    case (state)
      ST_IDLE:  if (accept) state_nxt = ST_ROW_Y;
      ST_ROW_Y: state_nxt = ST_ROW_U;
      ST_ROW_U: state_nxt = ST_ROW_V;
      ST_ROW_V: state_nxt = accept ? ST_ROW_Y : ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase
  end

  // Row select: coefficients, clamp mode and bypass channel follow the state.
  always_comb begin
    c_row        = coef_act[0 +: 3*COEF_W];
    clamp_signed = 1'b0;
    row_res      = en_h ? dot_res : r_h;
    case (state)
      ST_ROW_U: begin
        c_row        = coef_act[3*COEF_W +: 3*COEF_W];
        clamp_signed = 1'b1;
        row_res      = en_h ? dot_res : g_h;
      end
      ST_ROW_V: begin
        c_row        = coef_act[6*COEF_W +: 3*COEF_W];
        clamp_signed = 1'b1;
        row_res      = en_h ? dot_res : b_h;
      end
      default: ;
    endcase
  end

  yuv_dot3 #(.PIXEL_WIDTH(PIXEL_WIDTH)) u_dot3 (
    .a0           (r_h),
    .a1           (g_h),
    .a2           (b_h),
    .c0           (c_row[0 +: COEF_W]),
    .c1           (c_row[COEF_W +: COEF_W]),
    .c2           (c_row[2*COEF_W +: COEF_W]),
    .clamp_signed (clamp_signed),
    .res          (dot_res)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      coef_act   <= COEF_DEFAULT;
      coef_stg   <= COEF_DEFAULT;
      coef_pend  <= 1'b0;
      r_h        <= '0;
      g_h        <= '0;
      b_h        <= '0;
      en_h       <= 1'b0;
      dtype_h    <= '0;
      meta_h     <= '0;
      y_r        <= '0;
      u_r        <= '0;
      dvo        <= 1'b0;
      dtypeo     <= '0;
      y          <= '0;
      u          <= '0;
      v          <= '0;
      meta_datao <= '0;
    end else begin
      dvo <= 1'b0;
      // A load coinciding with a commit re-arms pend with the newer set.
      if (state == ST_IDLE && coef_pend) begin
        coef_act  <= coef_stg;
        coef_pend <= 1'b0;
      end
      if (coef_load) begin
        coef_stg  <= coef;
        coef_pend <= 1'b1;
      end
      if (accept) begin
        r_h     <= r;
        g_h     <= g;
        b_h     <= b;
        en_h    <= enable;
        dtype_h <= dtypei;
        meta_h  <= meta_datai;
      end
      if (state == ST_ROW_Y) y_r <= row_res;
      if (state == ST_ROW_U) u_r <= row_res;
      if (state == ST_ROW_V) begin
        dvo        <= 1'b1;
        y          <= y_r;
        u          <= u_r;
        v          <= row_res;
        dtypeo     <= dtype_h;
        meta_datao <= meta_h;
      end
    end
  end

endmodule

// File: tb/tb_yuv_matrix_seq.sv
// Directed self-checking bench for yuv_matrix_seq: latency, conversion values,
// bypass, back-to-back throughput, coefficient commit and mid-pixel reset.
`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH 4
`endif

module tb_yuv_matrix_seq;

  localparam int PW = 8;
  localparam int DW = `DTYPE_WIDTH;

  logic          clk = 1'b0;
  logic          resetb = 1'b0;
  logic          enable = 1'b1;
  logic          coef_load = 1'b0;
  logic [80:0]   coef = '0;
  logic          coef_pend;
  logic          dvi = 1'b0;
  logic          rdy;
  logic [DW-1:0] dtypei = '0;
  logic [PW-1:0] r = '0, g = '0, b = '0;
  logic [15:0]   meta_datai = '0;
  logic          dvo;
  logic [DW-1:0] dtypeo;
  logic [PW-1:0] y, u, v;
  logic [15:0]   meta_datao;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;

  typedef struct {
    logic [7:0]    y, u, v;
    logic [DW-1:0] dt;
    logic [15:0]   md;
    int            cyc;
  } out_t;
  out_t outq[$];

  yuv_matrix_seq #(.PIXEL_WIDTH(PW)) dut (
    .clk(clk), .resetb(resetb), .enable(enable), .coef_load(coef_load),
    .coef(coef), .coef_pend(coef_pend), .dvi(dvi), .rdy(rdy),
    .dtypei(dtypei), .r(r), .g(g), .b(b), .meta_datai(meta_datai),
    .dvo(dvo), .dtypeo(dtypeo), .y(y), .u(u), .v(v), .meta_datao(meta_datao)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) begin
    #1;
    if (dvo === 1'b1) outq.push_back('{y, u, v, dtypeo, meta_datao, cyc});
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  function automatic logic [80:0] mk_coef(input int yr, yg, yb, ur, ug, ub, vr, vg, vb);
    logic [80:0] s;
    int k[9];
    k = '{yr, yg, yb, ur, ug, ub, vr, vg, vb};
    for (int i = 0; i < 9; i++) s[i*9 +: 9] = 9'(k[i]);
    return s;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_and_check(input string nm, input logic [7:0] ir, ig, ib,
                                input logic ien, input logic [DW-1:0] idt,
                                input logic [15:0] imd, input logic [7:0] ey, eu, ev);
    int n;
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL %s_rdy: got %b expected 1", nm, rdy); end
    r = ir; g = ig; b = ib; enable = ien; dtypei = idt; meta_datai = imd; dvi = 1'b1;
    tick();
    dvi = 1'b0;
    n = 0;
    do begin tick(); n++; end while (dvo !== 1'b1 && n < 10);
    n_cmp++;
    if (n !== 3) begin n_bad++; $display("FAIL %s_latency: got %0d expected 3", nm, n); end
    n_cmp++;
    if (y !== ey) begin n_bad++; $display("FAIL %s_y: got %0h expected %0h", nm, y, ey); end
    n_cmp++;
    if (u !== eu) begin n_bad++; $display("FAIL %s_u: got %0h expected %0h", nm, u, eu); end
    n_cmp++;
    if (v !== ev) begin n_bad++; $display("FAIL %s_v: got %0h expected %0h", nm, v, ev); end
    n_cmp++;
    if (dtypeo !== idt) begin n_bad++; $display("FAIL %s_dtype: got %0h expected %0h", nm, dtypeo, idt); end
    n_cmp++;
    if (meta_datao !== imd) begin n_bad++; $display("FAIL %s_meta: got %0h expected %0h", nm, meta_datao, imd); end
    tick();
    n_cmp++;
    if (dvo !== 1'b0 || y !== ey || v !== ev) begin
      n_bad++; $display("FAIL %s_hold: got dvo=%b y=%0h v=%0h expected dvo=0 y=%0h v=%0h", nm, dvo, y, v, ey, ev);
    end
  endtask

  task automatic test_reset();
    resetb = 1'b0;
    repeat (3) @(posedge clk);
    #3 resetb = 1'b1;
    tick();
    n_cmp++;
    if ({dvo, y, u, v, dtypeo, meta_datao, coef_pend} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got dvo=%b y=%0h u=%0h v=%0h dt=%0h md=%0h pend=%b expected all 0",
                        dvo, y, u, v, dtypeo, meta_datao, coef_pend);
    end
    n_cmp++;
    if (rdy !== 1'b1) begin n_bad++; $display("FAIL reset_rdy: got %b expected 1", rdy); end
  endtask

  task automatic test_pixels();
    send_and_check("white", 8'd255, 8'd255, 8'd255, 1'b1, DW'(1), 16'hA5A5, 8'd219, 8'h00, 8'h00);
    send_and_check("red",   8'd255, 8'd0,   8'd0,   1'b1, DW'(2), 16'h1234, 8'd66,  8'hDA, 8'h70);
    send_and_check("black", 8'd0,   8'd0,   8'd0,   1'b1, DW'(3), 16'hBEEF, 8'd0,   8'h00, 8'h00);
  endtask

  task automatic test_back_to_back();
    logic [7:0] br[4], bg[4], bb[4], ey[4], eu[4], ev[4];
    logic       ben[4];
    int         acc[4];
    int         k;
    br = '{8'd255, 8'd10, 8'd255, 8'd0};  bg = '{8'd255, 8'd20, 8'd0, 8'd0};
    bb = '{8'd255, 8'd30, 8'd0, 8'd0};    ben = '{1'b1, 1'b0, 1'b1, 1'b1};
    ey = '{8'd219, 8'd10, 8'd66, 8'd0};   eu = '{8'h00, 8'd20, 8'hDA, 8'h00};
    ev = '{8'h00, 8'd30, 8'h70, 8'h00};
    outq.delete();
    for (int i = 0; i < 4; i++) begin
      r = br[i]; g = bg[i]; b = bb[i]; enable = ben[i];
      dtypei = DW'(i + 4); meta_datai = 16'h0100 + 16'(i); dvi = 1'b1;
      k = 0;
      while (rdy !== 1'b1 && k < 20) begin tick(); k++; end
      if (k >= 20) begin n_cmp++; n_bad++; $display("FAIL b2b_rdy_wait: got timeout expected rdy"); end
      tick();
      acc[i] = cyc;
    end
    dvi = 1'b0;
    repeat (6) tick();
    for (int i = 1; i < 4; i++) begin
      n_cmp++;
      if (acc[i] - acc[i-1] !== 3) begin
        n_bad++; $display("FAIL b2b_spacing%0d: got %0d expected 3", i, acc[i] - acc[i-1]);
      end
    end
    n_cmp++;
    if (outq.size() !== 4) begin
      n_bad++; $display("FAIL b2b_count: got %0d expected 4", outq.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (outq[i].y !== ey[i] || outq[i].u !== eu[i] || outq[i].v !== ev[i] ||
            outq[i].dt !== DW'(i + 4) || outq[i].md !== 16'h0100 + 16'(i) ||
            outq[i].cyc - acc[i] !== 3) begin
          n_bad++;
          $display("FAIL b2b_beat%0d: got y=%0h u=%0h v=%0h dt=%0h md=%0h lat=%0d expected y=%0h u=%0h v=%0h dt=%0h md=%0h lat=3",
                   i, outq[i].y, outq[i].u, outq[i].v, outq[i].dt, outq[i].md, outq[i].cyc - acc[i],
                   ey[i], eu[i], ev[i], DW'(i + 4), 16'h0100 + 16'(i));
        end
      end
    end
  endtask

  task automatic test_coef_load();
    int k;
    logic [7:0] ey[3], eu[3], ev[3];
    ey = '{8'd219, 8'd255, 8'd254}; eu = '{8'h00, 8'h00, 8'hDA}; ev = '{8'h00, 8'h80, 8'h80};
    outq.delete();
    r = 8'd255; g = 8'd255; b = 8'd255; enable = 1'b1; dtypei = '0; meta_datai = 16'h0; dvi = 1'b1;
    tick();
    dvi = 1'b0;
    coef = mk_coef(255, 255, 255, -38, -74, 112, -256, 0, 0);
    coef_load = 1'b1;
    tick();
    coef_load = 1'b0;
    n_cmp++;
    if (coef_pend !== 1'b1 || rdy !== 1'b0) begin
      n_bad++; $display("FAIL coef_pending: got pend=%b rdy=%b expected pend=1 rdy=0", coef_pend, rdy);
    end
    meta_datai = 16'h0001; dvi = 1'b1;
    k = 0;
    while (rdy !== 1'b1 && k < 20) begin tick(); k++; end
    n_cmp++;
    if (k !== 3 || coef_pend !== 1'b0) begin
      n_bad++; $display("FAIL coef_drain: got wait=%0d pend=%b expected wait=3 pend=0", k, coef_pend);
    end
    tick();
    r = 8'd255; g = 8'd0; b = 8'd0; meta_datai = 16'h0002;
    k = 0;
    while (rdy !== 1'b1 && k < 20) begin tick(); k++; end
    tick();
    dvi = 1'b0;
    repeat (5) tick();
    n_cmp++;
    if (outq.size() !== 3) begin
      n_bad++; $display("FAIL coef_count: got %0d expected 3", outq.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (outq[i].y !== ey[i] || outq[i].u !== eu[i] || outq[i].v !== ev[i] || outq[i].md !== 16'(i)) begin
          n_bad++;
          $display("FAIL coef_beat%0d: got y=%0h u=%0h v=%0h md=%0h expected y=%0h u=%0h v=%0h md=%0h",
                   i, outq[i].y, outq[i].u, outq[i].v, outq[i].md, ey[i], eu[i], ev[i], 16'(i));
        end
      end
    end
  endtask

  task automatic test_reset_midpixel();
    outq.delete();
    r = 8'd255; g = 8'd255; b = 8'd255; enable = 1'b1; dtypei = DW'(5); meta_datai = 16'h7777; dvi = 1'b1;
    coef = mk_coef(0, 0, 0, 0, 0, 0, 0, 0, 0);
    coef_load = 1'b1;
    tick();
    dvi = 1'b0; coef_load = 1'b0;
    tick();
    n_cmp++;
    if (coef_pend !== 1'b1) begin n_bad++; $display("FAIL rst_mid_prepend: got %b expected 1", coef_pend); end
    #2 resetb = 1'b0;
    #1;
    n_cmp++;
    if ({dvo, y, u, v, dtypeo, meta_datao, coef_pend} !== '0) begin
      n_bad++; $display("FAIL rst_mid_outputs: got dvo=%b y=%0h u=%0h v=%0h dt=%0h md=%0h pend=%b expected all 0",
                        dvo, y, u, v, dtypeo, meta_datao, coef_pend);
    end
    repeat (3) @(posedge clk);
    #3 resetb = 1'b1;
    repeat (5) tick();
    n_cmp++;
    if (outq.size() !== 0) begin n_bad++; $display("FAIL rst_mid_no_dvo: got %0d pulses expected 0", outq.size()); end
    n_cmp++;
    if (rdy !== 1'b1 || coef_pend !== 1'b0) begin
      n_bad++; $display("FAIL rst_mid_rdy: got rdy=%b pend=%b expected rdy=1 pend=0", rdy, coef_pend);
    end
    send_and_check("rst_white", 8'd255, 8'd255, 8'd255, 1'b1, DW'(6), 16'h00AA, 8'd219, 8'h00, 8'h00);
    send_and_check("rst_red",   8'd255, 8'd0,   8'd0,   1'b1, DW'(7), 16'h00BB, 8'd66,  8'hDA, 8'h70);
  endtask

  initial begin
    test_reset();
    test_pixels();
    test_back_to_back();
    test_coef_load();
    test_reset_midpixel();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
